// File: rtl/shinku_npu_pkg.sv
// Shared NPU types and sizes for the Ethernet TX datapath.
// Used by the TX arbiter and the TX FIFO controllers.
package shinku_npu_pkg;

    localparam int unsigned ETH_PKT_W     = 1048;
    localparam int unsigned TX_FIFO_DEPTH = 16;

    typedef logic [ETH_PKT_W-1:0] pkt_word_t;

endpackage

// File: rtl/ethernet_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: the search starts one past ptr and
// the first requesting index wins.
module rr_pick
    import shinku_npu_pkg::*;
#(
    parameter int unsigned NREQ = 2
) (
    input  logic [NREQ-1:0]          req,
    input  logic [$clog2(NREQ)-1:0]  ptr,
    output logic [NREQ-1:0]          gnt,
    output logic [$clog2(NREQ)-1:0]  idx,
    output logic                     any
);

    localparam int unsigned ID_W = $clog2(NREQ);

    int unsigned cand;

    // Walk the offsets in priority order; each offset maps to one candidate index.
    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = (32'(ptr) + k + 32'd1) % NREQ;
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (!any && req[i] && (cand == i)) begin
                    any    = 1'b1;
                    gnt[i] = 1'b1;
                    idx    = ID_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/ethernet_tx_arbiter.sv
// Round-robin arbiter sharing the TX FIFO write port between packet producers,
// with a registered output stage and an occupancy counter that throttles grants.
module ethernet_tx_arbiter
    import shinku_npu_pkg::*;
#(
    parameter int unsigned DATA_W     = ETH_PKT_W,
    parameter int unsigned NREQ       = 2,
    parameter int unsigned FIFO_DEPTH = TX_FIFO_DEPTH,
    parameter int unsigned AFULL_TH   = 14
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NREQ-1:0]                    req_valid,
    input  logic [NREQ*DATA_W-1:0]             req_data,
    output logic [NREQ-1:0]                    req_ready,
    output logic [DATA_W-1:0]                  fifo_din,
    output logic                               fifo_we,
    input  logic                               fifo_full,
    input  logic                               fifo_re,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    level,
    output logic [$clog2(NREQ)-1:0]            grant_id
);

    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned ID_W  = $clog2(NREQ);

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic [ID_W-1:0]   ptr_q,       ptr_d;
    logic [ID_W-1:0]   grant_id_q,  grant_id_d;
    logic [LVL_W-1:0]  level_q,     level_d;

    logic [NREQ-1:0]   pick_gnt;
    logic [ID_W-1:0]   pick_idx;
    logic              pick_any;
    logic              can_accept;
    logic              grant;
    logic [DATA_W-1:0] win_data;

    rr_pick #(
        .NREQ (NREQ)
    ) u_rr_pick (
        .req (req_valid),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Reset gates the strobes so a stale stage word never leaks out in the reset cycle.
    assign fifo_we    = out_valid_q & ~fifo_full & ~rst;
    assign can_accept = (~out_valid_q | fifo_we) & (level_q < LVL_W'(AFULL_TH)) & ~rst;
    assign grant      = can_accept & pick_any;
    assign req_ready  = can_accept ? pick_gnt : '0;

    assign fifo_din   = out_data_q;
    assign level      = level_q;
    assign grant_id   = grant_id_q;

    always_comb begin
        win_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (pick_gnt[i]) begin
                win_data = win_data | req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Output stage and pointer: load on grant, drain on write, otherwise hold.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        ptr_d       = ptr_q;
        grant_id_d  = grant_id_q;
        if (grant) begin
            out_valid_d = 1'b1;
            out_data_d  = win_data;
            ptr_d       = pick_idx;
            grant_id_d  = pick_idx;
        end else if (fifo_we) begin
            out_valid_d = 1'b0;
        end
    end

    // Occupancy tracking, saturating at both ends.
    always_comb begin
        level_d = level_q;
        if (fifo_we && !fifo_re) begin
            if (level_q != LVL_W'(FIFO_DEPTH)) begin
                level_d = level_q + LVL_W'(1);
            end
        end else if (fifo_re && !fifo_we && (level_q != '0)) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            ptr_q       <= ID_W'(NREQ - 1);
            grant_id_q  <= ID_W'(NREQ - 1);
            level_q     <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            ptr_q       <= ptr_d;
            grant_id_q  <= grant_id_d;
            level_q     <= level_d;
        end
    end

endmodule

// File: tb/tb_ethernet_tx_arbiter.sv
// Directed self-checking bench for ethernet_tx_arbiter (NREQ=2, depth 16, threshold 14).
module tb_ethernet_tx_arbiter;

    localparam int unsigned DATA_W = 1048;
    localparam int unsigned NREQ   = 2;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NREQ-1:0]          req_valid;
    logic [NREQ*DATA_W-1:0]   req_data;
    logic [NREQ-1:0]          req_ready;
    logic [DATA_W-1:0]        fifo_din;
    logic                     fifo_we;
    logic                     fifo_full;
    logic                     fifo_re;
    logic [4:0]               level;
    logic [0:0]               grant_id;

    int tests = 0;
    int fails = 0;

    ethernet_tx_arbiter #(
        .DATA_W     (DATA_W),
        .NREQ       (NREQ),
        .FIFO_DEPTH (16),
        .AFULL_TH   (14)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .fifo_din  (fifo_din),
        .fifo_we   (fifo_we),
        .fifo_full (fifo_full),
        .fifo_re   (fifo_re),
        .level     (level),
        .grant_id  (grant_id)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish required finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [DATA_W-1:0] w(input int unsigned n);
        w = DATA_W'({33{n}});
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h required %h", tag, obs[63:0], exp[63:0]);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        fifo_full = 1'b0;
        fifo_re   = 1'b0;
        tick();
        tick();

        // Reset values
        check("rst_level",    DATA_W'(level),     DATA_W'(0));
        check("rst_grant_id", DATA_W'(grant_id),  DATA_W'(1));
        check("rst_din",      fifo_din,           '0);
        check("rst_we",       DATA_W'(fifo_we),   DATA_W'(0));
        check("rst_ready",    DATA_W'(req_ready), DATA_W'(0));
        rst = 1'b0;

        // Single requester: A, B, C back-to-back
        req_valid = 2'b01;
        req_data[0 +: DATA_W] = w(32'hA);
        #1 check("single_ready", DATA_W'(req_ready), DATA_W'(2'b01));
        tick();
        req_data[0 +: DATA_W] = w(32'hB);
        #1;
        check("single_we1",  DATA_W'(fifo_we), DATA_W'(1));
        check("single_din1", fifo_din, w(32'hA));
        tick();
        req_data[0 +: DATA_W] = w(32'hC);
        #1;
        check("single_din2", fifo_din, w(32'hB));
        check("single_lvl1", DATA_W'(level), DATA_W'(1));
        tick();
        req_valid = 2'b00;
        #1;
        check("single_we3",  DATA_W'(fifo_we), DATA_W'(1));
        check("single_din3", fifo_din, w(32'hC));
        tick();
        check("single_lvl3", DATA_W'(level),   DATA_W'(3));
        check("single_idle", DATA_W'(fifo_we), DATA_W'(0));

        // Contention: both requesters hold valid, grants alternate from 0
        do_reset();
        req_valid = 2'b11;
        req_data[0 +: DATA_W]      = w(32'h100);
        req_data[DATA_W +: DATA_W] = w(32'h200);
        for (int k = 0; k < 6; k++) begin
            #1 check($sformatf("cont_ready%0d", k), DATA_W'(req_ready),
                     (k % 2 == 0) ? DATA_W'(2'b01) : DATA_W'(2'b10));
            tick();
            check($sformatf("cont_gid%0d", k), DATA_W'(grant_id), DATA_W'(k % 2));
            check($sformatf("cont_din%0d", k), fifo_din, (k % 2 == 0) ? w(32'h100) : w(32'h200));
        end
        req_valid = 2'b00;
        tick();
        check("cont_level", DATA_W'(level), DATA_W'(6));

        // Backpressure: X held through 5 full cycles, Y waits behind it
        req_valid = 2'b01;
        req_data[0 +: DATA_W] = w(32'h5A5A);
        #1 check("bp_ready_pre", DATA_W'(req_ready), DATA_W'(2'b01));
        tick();
        req_data[0 +: DATA_W] = w(32'h7777);
        for (int i = 0; i < 5; i++) begin
            fifo_full = 1'b1;
            #1;
            check($sformatf("bp_we%0d", i),    DATA_W'(fifo_we),   DATA_W'(0));
            check($sformatf("bp_din%0d", i),   fifo_din,           w(32'h5A5A));
            check($sformatf("bp_ready%0d", i), DATA_W'(req_ready), DATA_W'(0));
            tick();
        end
        fifo_full = 1'b0;
        #1;
        check("bp_release_we",    DATA_W'(fifo_we),   DATA_W'(1));
        check("bp_release_din",   fifo_din,           w(32'h5A5A));
        check("bp_release_ready", DATA_W'(req_ready), DATA_W'(2'b01));
        tick();
        req_valid = 2'b00;
        check("bp_next_din", fifo_din,       w(32'h7777));
        check("bp_level",    DATA_W'(level), DATA_W'(7));
        tick();

        // Threshold: 14 words fill to level 14, one read reopens one grant
        do_reset();
        req_valid = 2'b01;
        for (int i = 0; i < 14; i++) begin
            req_data[0 +: DATA_W] = w(32'h1000 + 32'(i));
            tick();
        end
        req_valid = 2'b00;
        tick();
        req_valid = 2'b01;
        req_data[0 +: DATA_W] = w(32'h2000);
        #1;
        check("th_level14", DATA_W'(level),     DATA_W'(14));
        check("th_ready0",  DATA_W'(req_ready), DATA_W'(0));
        fifo_re = 1'b1;
        tick();
        fifo_re = 1'b0;
        #1;
        check("th_level13", DATA_W'(level),     DATA_W'(13));
        check("th_ready1",  DATA_W'(req_ready), DATA_W'(2'b01));
        tick();
        req_valid = 2'b00;
        check("th_we",  DATA_W'(fifo_we), DATA_W'(1));
        check("th_din", fifo_din,         w(32'h2000));
        tick();
        check("th_back14", DATA_W'(level), DATA_W'(14));

        // Counter: simultaneous write and read at level 5
        do_reset();
        req_valid = 2'b01;
        req_data[0 +: DATA_W] = w(32'h55);
        for (int i = 0; i < 5; i++) tick();
        req_valid = 2'b00;
        tick();
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        fifo_re   = 1'b1;
        #1;
        check("cnt_pre5", DATA_W'(level),   DATA_W'(5));
        check("cnt_we",   DATA_W'(fifo_we), DATA_W'(1));
        tick();
        fifo_re = 1'b0;
        check("cnt_same5", DATA_W'(level), DATA_W'(5));

        // Counter: read at level 0 is ignored
        do_reset();
        fifo_re = 1'b1;
        tick();
        fifo_re = 1'b0;
        check("cnt_zero", DATA_W'(level), DATA_W'(0));

        // Reset while the stage holds a word
        req_valid = 2'b11;
        req_data[0 +: DATA_W]      = w(32'hAA);
        req_data[DATA_W +: DATA_W] = w(32'hBB);
        tick();
        check("mid_loaded", fifo_din, w(32'hAA));
        rst = 1'b1;
        #1;
        check("mid_rst_we",    DATA_W'(fifo_we),   DATA_W'(0));
        check("mid_rst_ready", DATA_W'(req_ready), DATA_W'(0));
        tick();
        rst = 1'b0;
        #1;
        check("mid_after_we",    DATA_W'(fifo_we),   DATA_W'(0));
        check("mid_after_din",   fifo_din,           '0);
        check("mid_after_level", DATA_W'(level),     DATA_W'(0));
        check("mid_after_gid",   DATA_W'(grant_id),  DATA_W'(1));
        check("mid_after_ready", DATA_W'(req_ready), DATA_W'(2'b01));
        tick();
        req_valid = 2'b00;
        check("mid_first_gid", DATA_W'(grant_id), DATA_W'(0));
        check("mid_first_din", fifo_din,          w(32'hAA));
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
